// File: rtl/centroid_update_8cen.sv
// Eight-entry centroid store: moves the winning centroid toward its observation by diff >>> LR_SHIFT.
// Optional macro UPDATE_MIN_STEP_EN forces a step of +/-1 when a nonzero diff would round to a zero step.
module centroid_update_8cen #(
    parameter int unsigned LR_SHIFT   = 4,
    parameter logic [15:0] RESET_STEP = 16'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] obs,
    input  logic [2:0]  arg,
    input  logic        init_we,
    input  logic [2:0]  init_addr,
    input  logic [15:0] init_data,
    output logic        upd_done,
    output logic        busy,
    output logic [15:0] a_000,
    output logic [15:0] a_001,
    output logic [15:0] a_010,
    output logic [15:0] a_011,
    output logic [15:0] a_100,
    output logic [15:0] a_101,
    output logic [15:0] a_110,
    output logic [15:0] a_111
);

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   cen_q [NC];
    logic [DW-1:0]   obs_q;
    logic [DW-1:0]   nxt_q;
    logic [2:0]      arg_q;
    logic            upd_done_q;

    logic [DW-1:0]        cen_sel_c;
    logic signed [DW:0]   diff_c;
    logic signed [DW:0]   step_c;
    logic [DW-1:0]        nxt_c;

    // Step toward the observation; the result always lies between c and obs, so it never wraps.
    always_comb begin
        cen_sel_c = cen_q[arg_q];
        diff_c    = $signed({1'b0, obs_q}) - $signed({1'b0, cen_sel_c});
        step_c    = diff_c >>> LR_SHIFT;
`ifdef UPDATE_MIN_STEP_EN
        if ((diff_c != '0) && (step_c == '0)) begin
            step_c = diff_c[DW] ? '1 : (DW+1)'(1);
        end
`endif
        nxt_c     = DW'({1'b0, cen_sel_c} + $unsigned(step_c));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            obs_q      <= '0;
            arg_q      <= '0;
            nxt_q      <= '0;
            upd_done_q <= 1'b0;
            for (int k = 0; k < NC; k++) begin
                cen_q[k] <= DW'(k * RESET_STEP);
            end
        end else begin
            upd_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Init writes take priority and block acceptance in the same cycle.
                    if (init_we) begin
                        cen_q[init_addr] <= init_data;
                    end else if (in_valid) begin
                        obs_q   <= obs;
                        arg_q   <= arg;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    nxt_q   <= nxt_c;
                    state_q <= WRITE;
                end
                WRITE: begin
                    cen_q[arg_q] <= nxt_q;
                    upd_done_q   <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE) && !init_we;
    assign busy     = (state_q != IDLE);
    assign upd_done = upd_done_q;

    assign a_000 = cen_q[0];
    assign a_001 = cen_q[1];
    assign a_010 = cen_q[2];
    assign a_011 = cen_q[3];
    assign a_100 = cen_q[4];
    assign a_101 = cen_q[5];
    assign a_110 = cen_q[6];
    assign a_111 = cen_q[7];

endmodule

// File: tb/tb_centroid_update_8cen.sv
// Bench for centroid_update_8cen: LR_SHIFT=4 instance plus an LR_SHIFT=0 instance fed the same stimulus.
module tb_centroid_update_8cen;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] obs;
    logic [2:0]  arg;
    logic        init_we;
    logic [2:0]  init_addr;
    logic [15:0] init_data;

    logic        in_ready, upd_done, busy;
    logic        in_ready0, upd_done0, busy0;
    logic [15:0] a4 [8];
    logic [15:0] a0 [8];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  arg;
        logic [15:0] obs;
        logic [15:0] exp4;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] model [8];

    centroid_update_8cen u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .obs(obs), .arg(arg), .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .upd_done(upd_done), .busy(busy),
        .a_000(a4[0]), .a_001(a4[1]), .a_010(a4[2]), .a_011(a4[3]),
        .a_100(a4[4]), .a_101(a4[5]), .a_110(a4[6]), .a_111(a4[7])
    );

    centroid_update_8cen #(.LR_SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .obs(obs), .arg(arg), .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .upd_done(upd_done0), .busy(busy0),
        .a_000(a0[0]), .a_001(a0[1]), .a_010(a0[2]), .a_011(a0[3]),
        .a_100(a0[4]), .a_101(a0[5]), .a_110(a0[6]), .a_111(a0[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) model[k] = 16'(k * 16'h2000);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 8; k++) check($sformatf("%s_a%0d", tag, k), 32'(a4[k]), 32'(model[k]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        init_we = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Issue one update and check the handshake/latency through the upd_done pulse.
    task automatic apply_update(input logic [2:0] a, input logic [15:0] o);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
            return;
        end
        in_valid = 1'b1;
        arg = a;
        obs = o;
        @(posedge clk); #1;
        in_valid = 1'b0;
        arg = ~a;
        obs = ~o;
        check("busy_calc", 32'(busy), 32'(1));
        check("done_calc", 32'(upd_done), 32'(0));
        @(posedge clk); #1;
        check("done_write", 32'(upd_done), 32'(0));
        @(posedge clk); #1;
        check("done_pulse", 32'(upd_done), 32'(1));
        check("ready_after", 32'(in_ready), 32'(1));
    endtask

    initial begin
        int          n_acc;
        int          n_done;
        int          acc_cyc [3];
        logic        acc;
        logic [15:0] db_exp;

`ifdef UPDATE_MIN_STEP_EN
        db_exp = 16'h2001;
`else
        db_exp = 16'h2000;
`endif
        vecs[0] = '{arg: 3'd3, obs: 16'h4000, exp4: 16'h5E00};
        vecs[1] = '{arg: 3'd0, obs: 16'h1000, exp4: 16'h0100};
        vecs[2] = '{arg: 3'd1, obs: 16'h2005, exp4: db_exp};
        vecs[3] = '{arg: 3'd1, obs: 16'h1FFB, exp4: 16'h1FFF};
        vecs[4] = '{arg: 3'd7, obs: 16'hFFFF, exp4: 16'hE1FF};
        vecs[5] = '{arg: 3'd5, obs: 16'hA000, exp4: 16'hA000};
        vecs[6] = '{arg: 3'd2, obs: 16'h0000, exp4: 16'h3C00};

        rst_n = 1'b0;
        in_valid = 1'b0;
        obs = '0;
        arg = '0;
        init_we = 1'b0;
        init_addr = '0;
        init_data = '0;
        model_reset();
        #12;
        check("rst_done", 32'(upd_done), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted while CALC is in flight must abort the update.
        @(negedge clk);
        in_valid = 1'b1;
        arg = 3'd3;
        obs = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_a000", 32'(a4[0]), 32'h0000);
        check("midrst_a011", 32'(a4[3]), 32'h6000);
        check("midrst_a111", 32'(a4[7]), 32'hE000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", 32'(in_ready), 32'(1));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("midrst_nodone", 32'(upd_done), 32'(0));
        end
        check("midrst_nowrite", 32'(a4[3]), 32'h6000);

        // Table: fresh reset, single update, full centroid compare on both instances.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            apply_update(vecs[i].arg, vecs[i].obs);
            model[vecs[i].arg] = vecs[i].exp4;
            check_all($sformatf("vec%0d", i));
            check($sformatf("vec%0d_lr0", i), 32'(a0[vecs[i].arg]), 32'(vecs[i].obs));
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse_end", i), 32'(upd_done), 32'(0));
        end

        // Init write collides with in_valid in IDLE: init wins, update accepted next cycle.
        do_reset();
        @(negedge clk);
        init_we = 1'b1;
        init_addr = 3'd2;
        init_data = 16'h1234;
        in_valid = 1'b1;
        arg = 3'd2;
        obs = 16'h0000;
        #1;
        check("coll_ready0", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        check("coll_init", 32'(a4[2]), 32'h1234);
        check("coll_idle", 32'(busy), 32'(0));
        @(negedge clk);
        init_we = 1'b0;
        #1;
        check("coll_ready1", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("coll_accept", 32'(busy), 32'(1));
        @(posedge clk);
        @(posedge clk); #1;
        check("coll_done", 32'(upd_done), 32'(1));
        check("coll_upd", 32'(a4[2]), 32'h1110);
        check("coll_upd_lr0", 32'(a0[2]), 32'h0000);

        // Init strobes while busy are dropped.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        arg = 3'd4;
        obs = 16'h8000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        init_we = 1'b1;
        init_addr = 3'd4;
        init_data = 16'hFFFF;
        @(posedge clk); #1;
        init_addr = 3'd6;
        @(posedge clk); #1;
        init_we = 1'b0;
        check("busyinit_done", 32'(upd_done), 32'(1));
        check("busyinit_a100", 32'(a4[4]), 32'h8000);
        check("busyinit_a110", 32'(a4[6]), 32'hC000);
        check("busyinit_lr0", 32'(a0[4]), 32'h8000);

        // Back-to-back: in_valid held high, arg stepping 0,1,2.
        do_reset();
        n_acc = 0;
        n_done = 0;
        acc_cyc = '{default: 0};
        @(negedge clk);
        in_valid = 1'b1;
        arg = 3'd0;
        obs = 16'h1000;
        for (int cyc = 0; cyc < 12; cyc++) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (upd_done) n_done++;
            if (acc) begin
                if (n_acc < 3) acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 3) arg = 3'(n_acc);
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(n_acc), 32'(3));
        check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(3));
        check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(3));
        check("b2b_dones", 32'(n_done), 32'(3));
        model[0] = 16'h0100;
        model[1] = 16'h1F00;
        model[2] = 16'h3D00;
        check_all("b2b");
        for (int k = 0; k < 3; k++) check($sformatf("b2b_lr0_%0d", k), 32'(a0[k]), 32'h1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/centroid_update_8cen.md
Name: centroid_update_8cen

Overview:
- Consumes the winner from the 8-centroid comparator stage: winning index plus the observation that produced it.
- Moves the winning 16-bit centroid toward the observation by a power-of-two learning rate.
- Holds all 8 centroids in registers and drives them back to the comparator's a_000..a_111 inputs, closing the clustering loop.
- Also provides an idle-time initialisation write port.

Parameters:
- LR_SHIFT, 4, learning-rate right-shift (step = diff / 2^LR_SHIFT); legal range 0..15.
- RESET_STEP, 16'h2000, reset value of centroid k = k * RESET_STEP (truncated to 16 bits).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  update request valid.
- in_ready  output  1  update request accepted when in_valid & in_ready.
- obs  input  16  observation value, unsigned.
- arg  input  3  winning centroid index from comparator.
- init_we  input  1  initialisation write strobe.
- init_addr  input  3  centroid index to initialise.
- init_data  input  16  initialisation value.
- upd_done  output  1  one-cycle pulse: centroid write-back complete.
- busy  output  1  high in CALC or WRITE.
- a_000..a_111  output  16 each  current centroid values, registered; index = suffix in binary.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, upd_done=0.
  - Centroid k = k*RESET_STEP (0x0000, 0x2000, ..., 0xE000).
  - Capture registers cleared.
  - Reset asserted mid-operation aborts the update; no partial write.
- FSM states IDLE, CALC, WRITE.
- IDLE:
  - in_ready = ~init_we (combinational from state).
  - If init_we: centroid[init_addr] <= init_data at the edge; stay IDLE; an in_valid that cycle is not accepted.
  - Else if in_valid: capture obs, arg; -> CALC.
- CALC:
  - diff = {1'b0,obs} - {1'b0,c[arg]} (17-bit signed).
  - step = diff >>> LR_SHIFT (arithmetic, floor rounding).
  - nxt = c[arg] + step, registered; -> WRITE.
  - nxt always lies between c and obs inclusive: no overflow or wrap possible, so no saturation logic.
- WRITE: centroid[arg_q] <= nxt; upd_done <= 1 (high the following cycle only); -> IDLE.
- in_ready=0 and busy=1 in CALC and WRITE; init_we is ignored there (dropped, not queued).
- Latency: accept edge E0; updated centroid visible on a_xxx and upd_done high after edge E0+2.
- Throughput: one update per 3 cycles. in_ready is high again in the cycle upd_done is high, so back-to-back is possible.
- Inputs obs/arg are sampled only at the accept edge; later changes have no effect.
- LR_SHIFT=0: centroid jumps to obs.

Optional Feature:
- Macro UPDATE_MIN_STEP_EN.
- Defined: if diff != 0 and step == 0, step is forced to +1 (diff>0) or -1 (diff<0). Centroids therefore always converge exactly to a persistent observation.
- Not defined: step of 0 leaves the centroid unchanged (dead-band of |diff| < 2^LR_SHIFT for positive diff; floor rounding already gives -1 for small negative diff).
- No port or latency difference.

Test Plan:
- Reset: hold rst_n low mid-CALC -> a_000=0x0000, a_011=0x6000, a_111=0xE000; upd_done=0, in_ready=1 after release; no write occurred.
- Decrease: arg=3, obs=0x4000, c=0x6000, LR_SHIFT=4 -> a_011=0x5E00 after E0+2; upd_done pulses exactly one cycle; other centroids unchanged.
- Increase and full jump:
  - arg=0, obs=0x1000 -> a_000=0x0100.
  - Rebuild with LR_SHIFT=0: obs=0xFFFF arg=7 -> a_111=0xFFFF.
- Dead-band, arg=1, c=0x2000:
  - obs=0x2005 -> without macro 0x2000, with UPDATE_MIN_STEP_EN 0x2001.
  - obs=0x1FFB -> 0x1FFF in both builds.
- Init/update collision:
  - init_we=1 (addr=2, data=0x1234) with in_valid=1 in IDLE -> a_010=0x1234, in_ready=0 that cycle, update accepted next cycle.
  - init_we during busy -> ignored.
- Back-to-back: in_valid held high with arg sequence 0,1,2 -> accepts every 3 cycles, three upd_done pulses, correct values per index.
